pulse_meter: RTL and testbench

//  Input-side counterpart to the LED blinker. Samples an asynchronous square-wave pin and

---
 rtl/pulse_meter_if.sv | 31 +++
 rtl/pulse_meter.sv | 115 +++++++++++
 tb/tb_pulse_meter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// pulse_meter_if: measurement bus of the pulse meter.
//   sig_in    - asynchronous input pin (driven by the source side)
//   clear     - synchronous restart of the measurement
//   period    - cycles between the last two rising edges
//   high_time - high cycles within the last reported period
//   valid     - one-cycle strobe, period/high_time just updated
//   stalled   - no rising edge seen within the timeout
//   level     - synchronised copy of sig_in
// master: the side that drives the pin and reads results.
// slave : the meter itself.
interface pulse_meter_if #(
  parameter int CNT_W = 24
);
  logic             sig_in;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stalled;
  logic             level;

  modport master (
    output sig_in, clear,
    input  period, high_time, valid, stalled, level
  );

  modport slave (
    input  sig_in, clear,
    output period, high_time, valid, stalled, level
  );
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures period and high time of a slow asynchronous square wave.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   pm   - pulse_meter_if.slave (sig_in/clear in; period/high_time/valid/stalled/level out)
// A three-flop chain synchronises the pin and gives edge detection. A free-running
// saturating counter is restarted on every rising edge; its value at the falling edge
// is the high time, its value at the next rising edge is the period. The first partial
// period after reset, clear or timeout is discarded.
module pulse_meter #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 16_000_000
) (
  input  logic         clk,
  input  logic         rst,
  pulse_meter_if.slave pm
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {WAIT_RISE, MEASURE} state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] hi_lat, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic rise, fall;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Synchroniser; s3 is only the edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pm.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State and measurement registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_RISE;
      cnt       <= '0;
      hi_lat    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hi_lat    <= hi_lat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  // Next-state logic. Priority: clear, then rise, then fall/timeout. A rise in the same
  // cycle the counter saturates still reports, so period can equal TIMEOUT exactly.
  always_comb begin
    state_d   = state;
    cnt_d     = (cnt == TMO) ? cnt : cnt + ONE;
    hi_lat_d  = hi_lat;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;

    if (pm.clear) begin
      state_d   = WAIT_RISE;
      cnt_d     = '0;
      hi_lat_d  = '0;
      period_d  = '0;
      high_d    = '0;
      stalled_d = 1'b0;
    end else if (rise) begin
      // Counter restarts at 1: the rise cycle itself is the first cycle of the period.
      cnt_d   = ONE;
      state_d = MEASURE;
      if (state == MEASURE) begin
        period_d  = cnt;
        high_d    = hi_lat;
        valid_d   = 1'b1;
        stalled_d = 1'b0;
      end
    end else begin
      if (fall && state == MEASURE)
        hi_lat_d = cnt;
      // Period and high_time keep their last values; only the stall flag changes.
      if (cnt == TMO) begin
        stalled_d = 1'b1;
        state_d   = WAIT_RISE;
      end
    end
  end

  assign pm.period    = period_q;
  assign pm.high_time = high_q;
  assign pm.valid     = valid_q;
  assign pm.stalled   = stalled_q;
  assign pm.level     = s2;

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed + randomized bench for pulse_meter (CNT_W=8, TIMEOUT=100).
// Reference model works on timestamps: the count in any cycle is the number of cycles
// since the last restart point, clipped to TIMEOUT.
module tb_pulse_meter;
  localparam int CNT_W = 8;
  localparam int TMO   = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_meter_if #(.CNT_W(CNT_W)) ifc ();

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .pm  (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid;
  bit prev_v;

  // model state
  int t, ref_c, fall_cnt, m_period, m_high;
  bit meas, m_stalled, m_valid;
  bit h0, h1, h2;  // pin samples from the last three edges (newest first)

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    t = 0; ref_c = 0; fall_cnt = 0; m_period = 0; m_high = 0;
    meas = 0; m_stalled = 0; m_valid = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endfunction

  // Evaluate cycle t at the edge that ends it, with inputs sampled at that edge.
  function automatic void m_edge(bit sv, bit cv);
    int  c;
    bit  rise, fall;
    c = t - ref_c;
    if (c > TMO) c = TMO;
    rise = h1 & ~h2;
    fall = ~h1 & h2;
    m_valid = 0;
    if (cv) begin
      m_period = 0; m_high = 0; m_stalled = 0; meas = 0; fall_cnt = 0;
      ref_c = t + 1;
    end else if (rise) begin
      if (meas) begin
        m_period = c; m_high = fall_cnt; m_valid = 1; m_stalled = 0;
      end
      meas  = 1;
      ref_c = t;
    end else begin
      if (fall && meas) fall_cnt = c;
      if (c == TMO) begin
        m_stalled = 1;
        meas = 0;
      end
    end
    h2 = h1; h1 = h0; h0 = sv; t++;
  endfunction

  task automatic tick(input bit sv, input bit cv);
    ifc.sig_in = sv;
    ifc.clear  = cv;
    @(posedge clk);
    m_edge(sv, cv);
    #1;
    chk("valid",     32'(ifc.valid),     32'(m_valid));
    chk("period",    32'(ifc.period),    m_period);
    chk("high_time", 32'(ifc.high_time), m_high);
    chk("stalled",   32'(ifc.stalled),   32'(m_stalled));
    chk("level",     32'(ifc.level),     32'(h1));
    chk("valid_back_to_back", 32'(ifc.valid & prev_v), 32'd0);
    prev_v  = ifc.valid;
    n_valid += int'(ifc.valid);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) tick(1'b1, 1'b0);
      repeat (lo) tick(1'b0, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},  32'(ifc.period),    32'd0);
    chk({tag, "_high"},    32'(ifc.high_time), 32'd0);
    chk({tag, "_valid"},   32'(ifc.valid),     32'd0);
    chk({tag, "_stalled"}, 32'(ifc.stalled),   32'd0);
    chk({tag, "_level"},   32'(ifc.level),     32'd0);
  endtask

  initial begin
    int hi, lo;
    rst = 1'b0; ifc.sig_in = 1'b0; ifc.clear = 1'b0;
    prev_v = 0; n_valid = 0;
    m_reset();

    // 1: reset holds everything at 0 while the pin toggles; then timeout from idle.
    #1 chk_zero("rst0");
    repeat (4) begin
      ifc.sig_in = ~ifc.sig_in;
      @(posedge clk); #1;
      chk_zero("rst_tog");
    end
    @(negedge clk);
    ifc.sig_in = 1'b0;
    rst = 1'b1;
    m_reset();
    repeat (100) tick(1'b0, 1'b0);
    chk("t1_not_yet_stalled", 32'(ifc.stalled), 32'd0);
    tick(1'b0, 1'b0);
    chk("t1_stalled", 32'(ifc.stalled), 32'd1);
    chk("t1_no_valid", n_valid, 32'd0);

    // 2: 8 high / 12 low; first rise silent, then period 20 / high 8.
    n_valid = 0;
    wave(8, 12, 6);
    chk("t2_nvalid", n_valid, 32'd5);
    chk("t2_period", 32'(ifc.period), 32'd20);
    chk("t2_high",   32'(ifc.high_time), 32'd8);
    chk("t2_stalled", 32'(ifc.stalled), 32'd0);
    tick(1'b1, 1'b0); chk("t2_lat_k",   32'(ifc.valid), 32'd0);
    tick(1'b1, 1'b0); chk("t2_lat_k1",  32'(ifc.valid), 32'd0);
    tick(1'b1, 1'b0); chk("t2_lat_k2",  32'(ifc.valid), 32'd1);
    repeat (5)  tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);

    // 3: narrow pulse after a restart.
    tick(1'b0, 1'b1);
    n_valid = 0;
    wave(1, 4, 6);
    chk("t3_nvalid", n_valid, 32'd5);
    chk("t3_period", 32'(ifc.period), 32'd5);
    chk("t3_high",   32'(ifc.high_time), 32'd1);

    // 4: stall after a running wave, then recovery.
    wave(8, 12, 3);
    repeat (120) tick(1'b0, 1'b0);
    chk("t4_stalled", 32'(ifc.stalled), 32'd1);
    chk("t4_period_hold", 32'(ifc.period), 32'd20);
    n_valid = 0;
    wave(8, 12, 1);
    chk("t4_first_rise_silent", n_valid, 32'd0);
    repeat (3) tick(1'b1, 1'b0);
    chk("t4_valid",   32'(ifc.valid), 32'd1);
    chk("t4_period",  32'(ifc.period), 32'd20);
    chk("t4_unstall", 32'(ifc.stalled), 32'd0);
    repeat (5)  tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);

    // 5: clear mid-period, and clear on the rise cycle.
    wave(8, 12, 2);
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("t5_period", 32'(ifc.period), 32'd0);
    chk("t5_high",   32'(ifc.high_time), 32'd0);
    chk("t5_stall",  32'(ifc.stalled), 32'd0);
    n_valid = 0;
    repeat (3)  tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    repeat (8)  tick(1'b1, 1'b0);
    chk("t5_rise_after_clear", n_valid, 32'd0);
    repeat (12) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    chk("t5_clear_on_rise", 32'(ifc.valid), 32'd0);
    repeat (5)  tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);

    // Boundary: period exactly TIMEOUT reports; TIMEOUT+1 stalls.
    tick(1'b0, 1'b1);
    n_valid = 0;
    wave(40, 60, 3);
    chk("b_nvalid_100", n_valid, 32'd2);
    chk("b_period_100", 32'(ifc.period), 32'd100);
    chk("b_no_stall",   32'(ifc.stalled), 32'd0);
    n_valid = 0;
    wave(40, 61, 2);
    repeat (3) tick(1'b1, 1'b0);
    chk("b_nvalid_101", n_valid, 32'd1);
    chk("b_stall_101",  32'(ifc.stalled), 32'd1);
    chk("b_period_hold", 32'(ifc.period), 32'd100);
    repeat (20) tick(1'b0, 1'b0);

    // Randomized waves with occasional clears and long periods.
    repeat (40) begin
      hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      repeat (hi) tick(1'b1, $urandom_range(0, 49) == 0);
      repeat (lo) tick(1'b0, $urandom_range(0, 49) == 0);
    end

    // 6: async reset between edges, then release with the pin high.
    wave(8, 12, 2);
    repeat (5) tick(1'b1, 1'b0);
    #3 rst = 1'b0;
    #1 chk_zero("t6_async");
    repeat (3) @(posedge clk);
    #1 chk_zero("t6_held");
    @(negedge clk);
    ifc.sig_in = 1'b1;
    rst = 1'b1;
    m_reset();
    prev_v = 0;
    n_valid = 0;
    repeat (10) tick(1'b1, 1'b0);
    chk("t6_first_rise_silent", n_valid, 32'd0);
    repeat (12) tick(1'b0, 1'b0);
    wave(8, 12, 3);
    chk("t6_nvalid", n_valid, 32'd3);
    chk("t6_period", 32'(ifc.period), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
